// File: rtl/mult_product_accumulator.sv
// Accumulates LEN unsigned multiplier products per window and presents the
// wrapped sum plus a sticky carry flag on a valid/ready output handshake.
module mult_product_accumulator #(
    parameter int N     = 2,
    parameter int ACC_W = 8,
    parameter int LEN   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2*N-1:0]               in_prod,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_sum,
    output logic                         out_ovf,
    output logic [$clog2(LEN+1)-1:0]     cnt
);

    localparam int CNT_W = $clog2(LEN+1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    typedef enum logic {ACC, HOLD} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic             ovf_sticky;
    logic [ACC_W:0]   sum_ext;
    logic             accept;
    logic             last_beat;

    // Returns {carry, sum} of the accumulator plus a zero-extended product.
    function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] a,
                                                input logic [2*N-1:0]   p);
        logic [ACC_W:0] p_ext;
        p_ext            = '0;
        p_ext[2*N-1:0]   = p;
        return {1'b0, a} + p_ext;
    endfunction

    assign in_ready  = (state == ACC) && !clr;
    assign accept    = in_valid && in_ready;
    assign sum_ext   = add_wide(acc, in_prod);
    assign last_beat = (cnt == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ACC;
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            out_ovf    <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (clr) begin
                        acc        <= '0;
                        cnt        <= '0;
                        ovf_sticky <= 1'b0;
                    end else if (accept) begin
                        if (last_beat) begin
                            out_sum    <= sum_ext[ACC_W-1:0];
                            out_ovf    <= ovf_sticky | sum_ext[ACC_W];
                            out_valid  <= 1'b1;
                            acc        <= '0;
                            cnt        <= '0;
                            ovf_sticky <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            acc        <= sum_ext[ACC_W-1:0];
                            cnt        <= cnt + CNT_W'(1);
                            ovf_sticky <= ovf_sticky | sum_ext[ACC_W];
                        end
                    end
                end
                // Result stays frozen until drained; clr has no effect here.
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Bench for mult_product_accumulator: directed plan steps plus a randomized
// run against a window-sum reference model; second instance covers overflow.
module tb_mult_product_accumulator;

    logic clk;
    logic rst_n;

    // Instance a: N=2, ACC_W=8, LEN=4
    logic       a_clr, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
    logic [3:0] a_in_prod;
    logic [7:0] a_out_sum;
    logic [2:0] a_cnt;

    // Instance b: N=2, ACC_W=4, LEN=2
    logic       b_clr, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
    logic [3:0] b_in_prod;
    logic [3:0] b_out_sum;
    logic [1:0] b_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state for instance a
    int   q[$];
    bit   m_hold;
    bit   m_valid;
    int   m_sum;
    bit   m_ovf;
    logic last_ready;

    mult_product_accumulator #(.N(2), .ACC_W(8), .LEN(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sum(a_out_sum), .out_ovf(a_out_ovf), .cnt(a_cnt)
    );

    mult_product_accumulator #(.N(2), .ACC_W(4), .LEN(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sum(b_out_sum), .out_ovf(b_out_ovf), .cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hold  = 0;
        m_valid = 0;
        m_sum   = 0;
        m_ovf   = 0;
    endtask

    // Window semantics: sum LEN accepted products; a carry happened iff the
    // true total reached 2^ACC_W.
    task automatic model_edge(input logic v, input logic [3:0] p, input logic r, input logic c);
        int total;
        if (m_hold) begin
            if (r) begin
                m_valid = 0;
                m_hold  = 0;
            end
        end else if (c) begin
            q.delete();
        end else if (v) begin
            q.push_back(int'(p));
            if (q.size() == 4) begin
                total = 0;
                foreach (q[i]) total += q[i];
                m_sum   = total % 256;
                m_ovf   = (total >= 256);
                m_valid = 1;
                m_hold  = 1;
                q.delete();
            end
        end
    endtask

    task automatic cyc_a(input logic v, input logic [3:0] p, input logic r, input logic c);
        a_in_valid  = v;
        a_in_prod   = p;
        a_out_ready = r;
        a_clr       = c;
        #1;
        last_ready = a_in_ready;
        chk("a_in_ready", a_in_ready, (!m_hold && !c));
        @(posedge clk);
        model_edge(v, p, r, c);
        #1;
        chk("a_out_valid", a_out_valid, m_valid);
        chk("a_out_sum", a_out_sum, m_sum);
        chk("a_out_ovf", a_out_ovf, m_ovf);
        chk("a_cnt", a_cnt, q.size());
    endtask

    task automatic tick_b();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        a_clr = 0; a_in_valid = 0; a_in_prod = 0; a_out_ready = 0;
        b_clr = 0; b_in_valid = 0; b_in_prod = 0; b_out_ready = 0;
        model_reset();
        #1;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_sum", a_out_sum, 0);
        chk("rst_out_ovf", a_out_ovf, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_b_out_valid", b_out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Overflow on the narrow instance, sticky flag cleared per window
        b_in_valid = 1; b_in_prod = 9; b_out_ready = 0;
        tick_b();
        chk("b_cnt_1", b_cnt, 1);
        b_in_prod = 9;
        tick_b();
        chk("b_ovf_valid", b_out_valid, 1);
        chk("b_ovf_sum", b_out_sum, 2);
        chk("b_ovf_flag", b_out_ovf, 1);
        b_in_valid = 0; b_out_ready = 1;
        tick_b();
        chk("b_drain_valid", b_out_valid, 0);
        chk("b_drain_sum_kept", b_out_sum, 2);
        b_in_valid = 1; b_in_prod = 1;
        tick_b();
        b_in_prod = 2;
        tick_b();
        chk("b_w2_valid", b_out_valid, 1);
        chk("b_w2_sum", b_out_sum, 3);
        chk("b_w2_ovf", b_out_ovf, 0);
        b_in_valid = 0;
        tick_b();
        chk("b_w2_drain", b_out_valid, 0);

        // Four products back to back
        for (int i = 0; i < 4; i++) cyc_a(1, 9, 1, 0);
        chk("t1_valid", a_out_valid, 1);
        chk("t1_sum", a_out_sum, 36);
        chk("t1_ovf", a_out_ovf, 0);
        cyc_a(1, 5, 1, 0);
        chk("t1_hold_ready", last_ready, 0);
        chk("t1_drop", a_out_valid, 0);

        // Backpressure holds the result
        for (int i = 1; i <= 4; i++) cyc_a(1, 4'(i), 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc_a(1, 4'($urandom_range(0, 15)), 0, 0);
            chk("t2_ready_held", last_ready, 0);
            chk("t2_sum_held", a_out_sum, 10);
        end
        cyc_a(0, 0, 1, 0);
        chk("t2_drain", a_out_valid, 0);
        cyc_a(1, 2, 1, 0);
        chk("t2_next_accept", a_cnt, 1);
        cyc_a(0, 0, 1, 1);

        // clr mid-window
        cyc_a(1, 5, 1, 0);
        cyc_a(1, 6, 1, 0);
        chk("t4_cnt_before", a_cnt, 2);
        cyc_a(1, 7, 1, 1);
        chk("t4_clr_ready", last_ready, 0);
        chk("t4_cnt_after", a_cnt, 0);
        for (int i = 0; i < 4; i++) cyc_a(1, 1, 0, 0);
        chk("t4_sum", a_out_sum, 4);

        // Asynchronous reset while holding a result
        chk("t5_in_hold", a_out_valid, 1);
        a_in_valid = 0; a_clr = 0; a_out_ready = 0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_valid", a_out_valid, 0);
        chk("t5_sum", a_out_sum, 0);
        chk("t5_cnt", a_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_ready", a_in_ready, 1);

        // Gapped input with undriven product between beats
        for (int i = 0; i < 4; i++) begin
            cyc_a(1, 3, 1, 0);
            if (i < 3) chk("t6_cnt", a_cnt, i + 1);
            cyc_a(0, 4'bxxxx, 1, 0);
        end
        chk("t6_sum", a_out_sum, 12);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
